jtkcpu_busctl: RTL

Bus controller placed directly downstream of the jtkcpu core. It derives the core's `cen`/`cen2` clock enables from the system clock, turns each CPU bus cycle into a request/acknowledge transaction on an external memory port, and stretches the CPU cycle (withholds `cen`) until memory acknowledges. Repeated reads of the same address skip the memory transaction and reuse the held byte.

---
 rtl/jtkcpu_bus_pkg.sv | 13 +
 rtl/jtkcpu_cendiv.sv | 31 +++
 rtl/jtkcpu_busctl.sv | 99 +++++++++
 3 files changed

// File: rtl/jtkcpu_bus_pkg.sv
// Shared types and constants for the jtkcpu bus controller.
package jtkcpu_bus_pkg;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] DIN_RST = 8'hFF;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/jtkcpu_cendiv.sv
// CPU cycle counter: wraps in RUN, saturates at its last slot while a memory access is pending.
module jtkcpu_cendiv #(
  parameter  int unsigned DIV = 4,
  localparam int unsigned CW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sat,
  output logic [CW-1:0] cnt,
  output logic          cen,
  output logic          cen2
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] MID  = CW'(DIV / 2 - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= sat ? LAST : '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Decoded from registered state only, so both enables are glitch-free.
  assign cen  = !sat && (cnt == LAST);
  assign cen2 = !sat && (cnt == MID);

endmodule

// File: rtl/jtkcpu_busctl.sv
// jtkcpu bus controller: cen/cen2 generation, memory request/ack handshake,
// CPU cycle stretching and reuse of the last byte read.
module jtkcpu_busctl
  import jtkcpu_bus_pkg::*;
#(
  parameter int unsigned DIV   = 4,
  parameter bit          REUSE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  output logic          cen,
  output logic          cen2,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_dout,
  input  logic [DW-1:0] mem_din,
  input  logic          mem_ok
);

  localparam int unsigned   CW  = $clog2(DIV);
  localparam logic [CW-1:0] MID = CW'(DIV / 2 - 1);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic            launch;
  logic            hit;
  logic            done;
  logic            hit_vld;
  logic [AW-1:0]   last_addr;

  jtkcpu_cendiv #(.DIV(DIV)) u_cendiv (
    .clk   (clk),
    .rst_n (rst_n),
    .sat   (state == WAIT),
    .cnt   (cnt),
    .cen   (cen),
    .cen2  (cen2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (launch && !hit) state_nx = WAIT;
      WAIT:    if (done)           state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Launch happens on the mid-cycle slot; a repeated read of the held byte skips memory.
  always_comb begin
    launch = 1'b0;
    hit    = 1'b0;
    done   = 1'b0;
    launch = (state == RUN) && (cnt == MID);
    hit    = REUSE && !cpu_we && hit_vld && (cpu_addr == last_addr);
    done   = (state == WAIT) && mem_req && mem_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_dout  <= '0;
      cpu_din   <= DIN_RST;
      hit_vld   <= 1'b0;
      last_addr <= '0;
    end else if (launch) begin
      mem_addr <= cpu_addr;
      mem_we   <= cpu_we;
      mem_dout <= cpu_dout;
      mem_req  <= !hit;
    end else if (done) begin
      mem_req <= 1'b0;
      if (mem_we) begin
        hit_vld <= 1'b0;
      end else begin
        cpu_din   <= mem_din;
        last_addr <= mem_addr;
        hit_vld   <= 1'b1;
      end
    end
  end

endmodule
